// File: rtl/shiftreg_uni.sv
// Parametrised universal shift register: logical/rotate/arithmetic shifts in either
// direction, plus a multi-step engine that performs `amount` steps with busy/done.
module shiftreg_uni #(
   parameter int unsigned      WIDTH  = 8,
   parameter int unsigned      CNT_W  = 4,
   parameter logic [WIDTH-1:0] SVALUE = '1
) (
   input  logic             clock,
   input  logic             aclr_n,
   input  logic             enable,
   input  logic             sclr,
   input  logic             sset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             shiftin,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic             shiftout,
   output logic [WIDTH-1:0] q
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_q, w_q;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_dir, w_dir;
   logic [1:0]       r_mode, w_mode;
   logic             r_done, w_done;

   // Mode 2'b11 falls through to logical behaviour.
   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v, input logic d,
                                                input logic [1:0] m, input logic si);
      logic [WIDTH-1:0] r;
      if (!d) begin
         case (m)
            2'b01:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            2'b10:   r = {v[WIDTH-2:0], 1'b0};
            default: r = {v[WIDTH-2:0], si};
         endcase
      end else begin
         case (m)
            2'b01:   r = {v[0], v[WIDTH-1:1]};
            2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {si, v[WIDTH-1:1]};
         endcase
      end
      return r;
   endfunction

   always_comb begin
      w_state = r_state;
      w_q     = r_q;
      w_cnt   = r_cnt;
      w_dir   = r_dir;
      w_mode  = r_mode;
      w_done  = 1'b0;
      if (enable) begin
         if (r_state == IDLE) begin
            if (sclr)      w_q = '0;
            else if (sset) w_q = SVALUE;
            else if (load) w_q = data;
            else if (start) begin
               if (amount == '0) begin
                  w_done = 1'b1;
               end else begin
                  w_state = RUN;
                  w_cnt   = amount;
                  w_dir   = dir;
                  w_mode  = mode;
               end
            end else begin
               w_q = f_step(r_q, dir, mode, shiftin);
            end
         end else begin
            // sclr/sset abort the run without a done pulse; load/start are ignored here.
            if (sclr) begin
               w_q     = '0;
               w_state = IDLE;
               w_cnt   = '0;
            end else if (sset) begin
               w_q     = SVALUE;
               w_state = IDLE;
               w_cnt   = '0;
            end else begin
               w_q   = f_step(r_q, r_dir, r_mode, shiftin);
               w_cnt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_state = IDLE;
                  w_done  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_mode  <= 2'b00;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_q     <= w_q;
         r_cnt   <= w_cnt;
         r_dir   <= w_dir;
         r_mode  <= w_mode;
         r_done  <= w_done;
      end
   end

   assign q        = r_q;
   assign busy     = (r_state == RUN);
   assign done     = r_done;
   assign shiftout = dir ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_uni.sv
// Scoreboard bench for shiftreg_uni: a cycle model pushes expected q/busy/done per edge,
// popped and compared after the edge, plus fixed reference values for key scenarios.
module tb_shiftreg_uni;

   logic       clock = 1'b0;
   logic       aclr_n, enable, sclr, sset, load, dir, shiftin, start;
   logic [7:0] data;
   logic [1:0] mode;
   logic [3:0] amount;
   logic       busy, done, shiftout;
   logic [7:0] q;

   shiftreg_uni #(.WIDTH(8), .CNT_W(4), .SVALUE(8'hFF)) dut (
      .clock(clock), .aclr_n(aclr_n), .enable(enable), .sclr(sclr), .sset(sset),
      .load(load), .data(data), .dir(dir), .mode(mode), .shiftin(shiftin),
      .start(start), .amount(amount), .busy(busy), .done(done),
      .shiftout(shiftout), .q(q)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t  sb[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   string cur    = "init";

   logic [7:0] m_q    = '0;
   logic       m_run  = 1'b0;
   int         m_cnt  = 0;
   logic       m_dir  = 1'b0;
   logic [1:0] m_mode = '0;
   logic       m_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s/%s observed=%0h expected=%0h t=%0t", cur, tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] mshift(input logic [7:0] v, input logic d,
                                         input logic [1:0] m, input logic si);
      logic [7:0] r;
      if (!d) begin
         r = v << 1;
         if (m == 2'b01)      r = r | (v >> 7);
         else if (m != 2'b10) r = r | {7'b0, si};
      end else begin
         r = v >> 1;
         if (m == 2'b01)      r = r | (v << 7);
         else if (m == 2'b10) r = 8'($signed(v) >>> 1);
         else                 r = r | {si, 7'b0};
      end
      return r;
   endfunction

   task automatic model_reset();
      m_q = '0; m_run = 1'b0; m_cnt = 0; m_done = 1'b0;
   endtask

   // Advance the model with the inputs as they stand, then clock the DUT and compare.
   task automatic cyc();
      exp_t e;
      m_done = 1'b0;
      if (enable) begin
         if (!m_run) begin
            if (sclr)      m_q = 8'h00;
            else if (sset) m_q = 8'hFF;
            else if (load) m_q = data;
            else if (start) begin
               if (amount == 0) m_done = 1'b1;
               else begin
                  m_run = 1'b1; m_cnt = int'(amount); m_dir = dir; m_mode = mode;
               end
            end else m_q = mshift(m_q, dir, mode, shiftin);
         end else begin
            if (sclr)      begin m_q = 8'h00; m_run = 1'b0; end
            else if (sset) begin m_q = 8'hFF; m_run = 1'b0; end
            else begin
               m_q = mshift(m_q, m_dir, m_mode, shiftin);
               m_cnt--;
               if (m_cnt == 0) begin m_run = 1'b0; m_done = 1'b1; end
            end
         end
      end
      e = '{q: m_q, busy: m_run, done: m_done};
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
   endtask

   task automatic quiet();
      enable = 0; sclr = 0; sset = 0; load = 0; start = 0;
   endtask

   task automatic do_load(input logic [7:0] v);
      quiet(); enable = 1; load = 1; data = v;
      cyc();
      quiet();
   endtask

   task automatic do_start(input logic [3:0] n, input logic d, input logic [1:0] m);
      quiet(); enable = 1; start = 1; amount = n; dir = d; mode = m;
      cyc();
      start = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      aclr_n = 0; quiet(); data = '0; dir = 0; mode = 0; shiftin = 0; amount = '0;
      #2;
      cur = "por";
      chk("q", 32'(q), 32'h00);
      chk("busy", 32'(busy), 0);
      chk("done", 32'(done), 0);
      chk("shiftout", 32'(shiftout), 0);
      @(posedge clock); #1;
      aclr_n = 1;

      cur = "reset_mid_run";
      do_load(8'h5A);
      do_start(4'd5, 1'b0, 2'b00);
      chk("busy_run", 32'(busy), 1);
      cyc(); cyc();
      aclr_n = 0;
      #1;
      chk("q_async", 32'(q), 32'h00);
      chk("busy_async", 32'(busy), 0);
      chk("done_async", 32'(done), 0);
      chk("shiftout_async", 32'(shiftout), 0);
      @(posedge clock); #1;
      chk("q_held", 32'(q), 32'h00);
      model_reset();
      aclr_n = 1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("no_done", 32'(done), 0);
      end
      quiet();

      cur = "rotate_left";
      do_load(8'hA5);
      do_start(4'd3, 1'b0, 2'b01);
      chk("q_k", 32'(q), 32'hA5);
      dir = 1; mode = 2'b10;
      cyc(); chk("q1", 32'(q), 32'h4B); chk("busy1", 32'(busy), 1);
      cyc(); chk("q2", 32'(q), 32'h96); chk("busy2", 32'(busy), 1);
      cyc(); chk("q3", 32'(q), 32'h2D); chk("done3", 32'(done), 1); chk("busy3", 32'(busy), 0);
      quiet(); cyc(); chk("done_once", 32'(done), 0);

      cur = "arith_right";
      do_load(8'h90);
      do_start(4'd2, 1'b1, 2'b10);
      cyc(); cyc();
      chk("q_E4", 32'(q), 32'hE4); chk("done", 32'(done), 1);
      do_load(8'h10);
      do_start(4'd2, 1'b1, 2'b10);
      cyc(); cyc();
      chk("q_04", 32'(q), 32'h04); chk("done", 32'(done), 1);

      cur = "stall";
      shiftin = 0;
      do_load(8'h01);
      do_start(4'd4, 1'b0, 2'b00);
      cyc(); chk("q_step1", 32'(q), 32'h02);
      enable = 0; cyc(); cyc();
      chk("busy_stalled", 32'(busy), 1);
      enable = 1; cyc(); cyc();
      chk("not_done_yet", 32'(done), 0);
      cyc();
      chk("q_final", 32'(q), 32'h10); chk("done_late", 32'(done), 1);

      cur = "abort_sclr";
      do_load(8'h01);
      do_start(4'd4, 1'b0, 2'b00);
      cyc(); cyc();
      sclr = 1; cyc(); sclr = 0;
      chk("q", 32'(q), 32'h00); chk("idle", 32'(busy), 0); chk("no_done", 32'(done), 0);
      cyc(); cyc();
      chk("no_done_later", 32'(done), 0);

      cur = "abort_sset";
      do_load(8'h01);
      do_start(4'd4, 1'b0, 2'b00);
      cyc(); cyc();
      sset = 1; cyc(); sset = 0;
      chk("q", 32'(q), 32'hFF); chk("idle", 32'(busy), 0); chk("no_done", 32'(done), 0);
      enable = 0; cyc();

      cur = "serial";
      quiet(); enable = 1; sclr = 1; cyc(); sclr = 0;
      mode = 2'b00; dir = 0;
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] pat;
         pat = 4'b1011;
         shiftin = pat[i];
         cyc();
         chk("shiftout_msb", 32'(shiftout), 32'(m_q[7]));
      end
      chk("q_0B", 32'(q), 32'h0B);
      enable = 0; dir = 1; #1;
      chk("shiftout_lsb", 32'(shiftout), 32'(m_q[0]));
      enable = 1; shiftin = 0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("shiftout_lsb_step", 32'(shiftout), 32'(m_q[0]));
      end
      quiet();

      cur = "amount_zero";
      do_load(8'h3C);
      do_start(4'd0, 1'b0, 2'b01);
      chk("q", 32'(q), 32'h3C); chk("busy", 32'(busy), 0); chk("done", 32'(done), 1);
      enable = 0; cyc();
      chk("done_drop", 32'(done), 0);

      cur = "ignore_in_run";
      do_load(8'h81);
      do_start(4'd3, 1'b0, 2'b01);
      load = 1; data = 8'hFF; cyc(); load = 0;
      chk("q_03", 32'(q), 32'h03);
      start = 1; amount = 4'd7; cyc(); start = 0;
      chk("q_06", 32'(q), 32'h06);
      cyc();
      chk("q_0C", 32'(q), 32'h0C); chk("done", 32'(done), 1);

      cur = "back_to_back";
      start = 1; amount = 4'd2; dir = 1; mode = 2'b01;
      cyc(); start = 0;
      chk("busy_again", 32'(busy), 1); chk("q_hold", 32'(q), 32'h0C);
      cyc(); cyc();
      chk("q_03", 32'(q), 32'h03); chk("done", 32'(done), 1);
      quiet(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shiftreg_uni.md
# shiftreg_uni

Parametrised universal shift register; successor to the fixed 8-bit LPM-style shift register in this codebase. Adds runtime direction, logical/rotate/arithmetic modes and a multi-step shift engine: a `start` request shifts `amount` positions, one per enabled clock, with `busy`/`done` handshake. Intended for serialisers, barrel-less bit alignment and test-pattern generation.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits, minimum 2.
- `CNT_W`, 4: width of `amount` and the internal step counter.
- `SVALUE`, all ones (`{WIDTH{1'b1}}`): value loaded by `sset`.

Ports:
- `clock`  in  1  rising-edge clock, the only clock.
- `aclr_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  clock enable; gates every synchronous operation.
- `sclr`  in  1  synchronous clear.
- `sset`  in  1  synchronous set to `SVALUE`.
- `load`  in  1  synchronous parallel load of `data`.
- `data`  in  WIDTH  parallel load value.
- `dir`  in  1  0 = left (toward MSB), 1 = right (toward LSB).
- `mode`  in  2  00 logical, 01 rotate, 10 arithmetic, 11 treated as logical.
- `shiftin`  in  1  serial fill bit for logical mode.
- `start`  in  1  request a multi-step shift of `amount` positions.
- `amount`  in  CNT_W  number of steps for `start`.
- `busy`  out  1  multi-step shift in progress.
- `done`  out  1  one-cycle pulse: multi-step shift complete.
- `shiftout`  out  1  bit leaving on the next shift: `q[WIDTH-1]` if `dir`=0, `q[0]` if `dir`=1. Combinational from `q` and live `dir`.
- `q`  out  WIDTH  register contents.

## Operation
- Single step, left: logical `{q[W-2:0],shiftin}`; rotate `{q[W-2:0],q[W-1]}`; arithmetic `{q[W-2:0],1'b0}`.
- Single step, right: logical `{shiftin,q[W-1:1]}`; rotate `{q[0],q[W-1:1]}`; arithmetic `{q[W-1],q[W-1:1]}`.
- States: IDLE, RUN.
- IDLE, `enable`=1, priority: `sclr` > `sset` > `load` > `start` > single step using live `dir`/`mode`.
- `start` in IDLE:
  - `amount`=N≥1: latch N, `dir`, `mode` into the engine; q unchanged; go to RUN.
  - `amount`=0: q unchanged; `done` pulses; stay in IDLE.
- RUN, `enable`=1:
  - `sclr`/`sset` apply, abort the operation, go to IDLE, no `done`.
  - Otherwise one step using latched `dir`/`mode`; `shiftin` is sampled live in logical mode; counter decrements.
  - On the step that brings the counter to 0: `done` pulses, go to IDLE.
  - `load` and `start` are ignored in RUN.
- `enable`=0: hold everything, any state; counter frozen; `done` forced 0.
- `amount` greater than WIDTH is legal; the shift continues wrapping per mode.

## Timing
- `aclr_n` low: immediately q=0, `busy`=0, `done`=0, counter=0, state IDLE; `shiftout`=0. Release is synchronous to the next edge.
- Reset dominates all inputs, including mid-RUN.
- `start` sampled at edge k with N≥1 and `enable` held high:
  - `busy`=1 after edge k through edge k+N-1 (N cycles).
  - Shifts occur at edges k+1 … k+N.
  - After edge k+N: q final, `busy`=0, `done`=1 for exactly one cycle.
  - Each `enable`=0 cycle in RUN delays completion by one cycle.
- `start` with `amount`=0 at edge k: `done`=1 for the cycle after edge k; `busy` stays 0.
- Single step, load, `sclr`, `sset`: one cycle latency; q updates at the sampling edge.
- `start` may be asserted in the cycle `done` is high; it is accepted, back-to-back.

## Test plan
- Reset: drive q=8'h5A, start N=5, then pulse `aclr_n` low mid-RUN -> q=8'h00, `busy`=0, `done`=0 immediately; no `done` afterwards.
- Rotate: load 8'hA5, then start `amount`=3, `dir`=0, `mode`=01 -> q 4B, 96, 2D on successive edges; `busy` high for 3 cycles; `done` high for one cycle with q=8'h2D.
- Arithmetic right: load 8'h90, then start `amount`=2, `dir`=1, `mode`=10 -> q=8'hE4, `done` pulse; repeat with 8'h10 -> q=8'h04.
- Stall and abort: start `amount`=4 on 8'h01 left logical with `shiftin`=0, drop `enable` for 2 cycles after step 1 -> `done` 2 cycles late, q=8'h10. Rerun and assert `sclr` after step 2 -> q=8'h00, IDLE, no `done`. Rerun with `sset` -> q=8'hFF.
- Single step and serial: from q=8'h00, `mode`=00, `dir`=0, `shiftin` 1,0,1,1 -> q=8'h0B; `shiftout` tracks q[7]. With `dir`=1, `shiftout` tracks q[0].
- Edge cases: `amount`=0 -> `done` next cycle, `busy`=0, q unchanged. `load` and `start` during RUN are ignored. `start` on the `done` cycle -> new run begins, `busy` re-asserts immediately.
